// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: fetches instruction words over a req/ack memory handshake,
// holds the current word and presents its opcode to the controller. Owns the PC:
// sequential increment, direct jump, external redirect and halt.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | raise the request at the next edge with the address from PC
// S_WAIT  | request held steady until the memory acks
// S_ISSUE | instruction held and valid; leaves when not stalled or redirected
// S_HALT  | halt opcode issued; fetching stopped until reset
module instr_fetch_issue #(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'b1111,
  parameter logic [3:0]      JUMP_OP  = 4'b1110
) (
  input  logic               clk,
  input  logic               rst,
  output logic               Imem_Req,
  output logic [ADDR_W-1:0]  Imem_Addr,
  input  logic               Imem_Ack,
  input  logic [INSTR_W-1:0] Imem_Data,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  Redirect_Addr,
  output logic [3:0]         Op_Code,
  output logic [INSTR_W-1:0] Instr,
  output logic               Instr_Valid,
  output logic [ADDR_W-1:0]  Pc_Out,
  output logic               Halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_pc, w_pc;
  logic                r_req, w_req;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [INSTR_W-1:0]  r_instr, w_instr;
  logic [ADDR_W-1:0]   r_pc_out, w_pc_out;
  logic                r_pend, w_pend;
  logic [ADDR_W-1:0]   r_pend_addr, w_pend_addr;

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_jump_pc;
  logic [ADDR_W-1:0]   w_pc_inc;

  // The jump keeps the upper page of the held instruction's address and
  // replaces the low 12 bits with the immediate field.
  assign w_op      = r_instr[INSTR_W-1 -: 4];
  assign w_jump_pc = {r_pc_out[ADDR_W-1:12], r_instr[11:0]};
  assign w_pc_inc  = r_pc_out + ADDR_W'(1);

  assign Imem_Req    = r_req;
  assign Imem_Addr   = r_addr;
  assign Op_Code     = w_op;
  assign Instr       = r_instr;
  assign Instr_Valid = (r_state == S_ISSUE);
  assign Pc_Out      = r_pc_out;
  assign Halted      = (r_state == S_HALT);

  // State and datapath registers; reset wins over any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_pc_out    <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_req       <= w_req;
      r_addr      <= w_addr;
      r_instr     <= w_instr;
      r_pc_out    <= w_pc_out;
      r_pend      <= w_pend;
      r_pend_addr <= w_pend_addr;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_req       = r_req;
    w_addr      = r_addr;
    w_instr     = r_instr;
    w_pc_out    = r_pc_out;
    w_pend      = r_pend;
    w_pend_addr = r_pend_addr;
    case (r_state)
      S_FETCH: begin
        // Request not yet visible, so a redirect simply replaces the address.
        w_req   = 1'b1;
        w_pend  = 1'b0;
        w_state = S_WAIT;
        if (Redirect) begin
          w_pc   = Redirect_Addr;
          w_addr = Redirect_Addr;
        end else begin
          w_addr = r_pc;
        end
      end
      S_WAIT: begin
        if (Imem_Ack) begin
          w_req = 1'b0;
          // A redirect arriving together with the ack also discards the word.
          if (r_pend || Redirect) begin
            w_pc    = Redirect ? Redirect_Addr : r_pend_addr;
            w_pend  = 1'b0;
            w_state = S_FETCH;
          end else begin
            w_instr  = Imem_Data;
            w_pc_out = r_pc;
            w_state  = S_ISSUE;
          end
        end else if (Redirect) begin
          // Request cannot be withdrawn; remember the latest target instead.
          w_pend      = 1'b1;
          w_pend_addr = Redirect_Addr;
        end
      end
      S_ISSUE: begin
        if (Redirect) begin
          w_pc    = Redirect_Addr;
          w_state = S_FETCH;
        end else if (!Stall) begin
          if (w_op == HALT_OP) begin
            w_state = S_HALT;
          end else if (w_op == JUMP_OP) begin
            w_pc    = w_jump_pc;
            w_state = S_FETCH;
          end else begin
            w_pc    = w_pc_inc;
            w_state = S_FETCH;
          end
        end
      end
      default: begin
        w_state = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: a procedural program-flow model drives inputs and
// states the expected outputs for each cycle; one compare process checks them.
module tb_instr_fetch_issue;

  logic        clk;
  logic        rst;
  logic        Imem_Req;
  logic [15:0] Imem_Addr;
  logic        Imem_Ack;
  logic [15:0] Imem_Data;
  logic        Stall;
  logic        Redirect;
  logic [15:0] Redirect_Addr;
  logic [3:0]  Op_Code;
  logic [15:0] Instr;
  logic        Instr_Valid;
  logic [15:0] Pc_Out;
  logic        Halted;

  instr_fetch_issue dut (
    .clk(clk), .rst(rst),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
    .Stall(Stall), .Redirect(Redirect), .Redirect_Addr(Redirect_Addr),
    .Op_Code(Op_Code), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .Pc_Out(Pc_Out), .Halted(Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_no;

  // expectations for the current cycle
  bit          chk_en = 0;
  bit          exp_req, exp_valid, exp_halted;
  logic [15:0] exp_addr;
  logic [15:0] cur_instr, cur_pcout;

  // scenario knobs
  int          fix_delay, sc_redir_cyc, sc_st_from, sc_st_to, sc_rst_cyc;
  logic [15:0] sc_redir_addr;
  int          p_stall, p_redir, p_rst;

  logic [15:0] mem [logic [15:0]];

  typedef struct { int c; logic [15:0] a; logic [15:0] w; } ev_t;
  ev_t fet_q[$];
  ev_t iss_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_no, act, expv);
    end
  endtask

  // compare process, half a cycle after the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", 32'(Imem_Req), 32'(exp_req));
      if (exp_req) chk("addr", 32'(Imem_Addr), 32'(exp_addr));
      chk("valid", 32'(Instr_Valid), 32'(exp_valid));
      chk("halted", 32'(Halted), 32'(exp_halted));
      chk("instr", 32'(Instr), 32'(cur_instr));
      chk("opcode", 32'(Op_Code), 32'(cur_instr[15:12]));
      chk("pc_out", 32'(Pc_Out), 32'(cur_pcout));
    end
  end

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [15:0] w;
    if (!mem.exists(a)) begin
      w = 16'($urandom);
      if ($urandom_range(99) < 4) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      mem[a] = w;
    end
    return mem[a];
  endfunction

  function automatic bit want_redir();
    return (cyc_no == sc_redir_cyc) || (int'($urandom_range(99)) < p_redir);
  endfunction

  function automatic logic [15:0] redir_addr();
    return (cyc_no == sc_redir_cyc) ? sc_redir_addr : 16'($urandom);
  endfunction

  function automatic bit want_stall();
    return (cyc_no >= sc_st_from && cyc_no <= sc_st_to) || (int'($urandom_range(99)) < p_stall);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic begin_cycle(input bit rq, input logic [15:0] ad, input bit vl, input bit hl);
    exp_req = rq; exp_addr = ad; exp_valid = vl; exp_halted = hl; chk_en = 1;
    rst = 0; Imem_Ack = 0; Imem_Data = 16'($urandom);
    Stall = 1'($urandom_range(1)); Redirect = 0; Redirect_Addr = 16'($urandom);
  endtask

  task automatic setup(input int fd, input int rc, input logic [15:0] ra, input int sf, input int st,
                       input int rstc, input int ps, input int pr, input int prst);
    fix_delay = fd; sc_redir_cyc = rc; sc_redir_addr = ra; sc_st_from = sf; sc_st_to = st;
    sc_rst_cyc = rstc; p_stall = ps; p_redir = pr; p_rst = prst;
    mem.delete(); fet_q.delete(); iss_q.delete();
  endtask

  // Program-flow model: fetch, wait for ack, issue, then pick the next PC.
  task automatic run_prog(input int budget);
    logic [15:0] pc, tgt;
    bit pend, rs, stl, red, halt;
    int d, n;
    begin_cycle(0, '0, 0, 0);
    chk_en = 0; rst = 1; cyc_no = -1;
    step();
    cur_instr = 16'h0000; cur_pcout = 16'h0000; pc = 16'h0000; n = 0;
    while (n < budget) begin
      // fetch cycle: request not yet visible
      begin_cycle(0, '0, 0, 0);
      if (want_redir()) begin
        Redirect = 1; Redirect_Addr = redir_addr(); pc = Redirect_Addr;
      end
      step(); n++;
      // wait cycles
      d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 4));
      pend = 0; rs = 0; tgt = '0;
      for (int k = 0; k <= d; k++) begin
        begin_cycle(1, pc, 0, 0);
        if (k == 0) fet_q.push_back('{cyc_no, pc, 16'h0});
        if (k == d) begin Imem_Ack = 1; Imem_Data = mem_rd(pc); end
        if (want_redir()) begin
          Redirect = 1; Redirect_Addr = redir_addr(); pend = 1; tgt = Redirect_Addr;
        end
        if (cyc_no == sc_rst_cyc || int'($urandom_range(999)) < p_rst) begin
          rs = 1; sc_rst_cyc = -1; rst = 1; Imem_Ack = 1; Imem_Data = 16'hABCD;
        end
        step(); n++;
        if (rs) break;
      end
      if (rs) begin
        cur_instr = 16'h0000; cur_pcout = 16'h0000; pc = 16'h0000; cyc_no = 0;
        continue;
      end
      if (pend) begin pc = tgt; continue; end
      cur_instr = mem_rd(pc); cur_pcout = pc;
      iss_q.push_back('{cyc_no, pc, cur_instr});
      // issue cycles
      halt = 0;
      forever begin
        begin_cycle(0, '0, 1, 0);
        stl = want_stall(); Stall = stl;
        red = want_redir();
        if (red) begin Redirect = 1; Redirect_Addr = redir_addr(); end
        step(); n++;
        if (red) begin pc = Redirect_Addr; break; end
        if (!stl) begin
          if (cur_instr[15:12] == 4'hF) halt = 1;
          else if (cur_instr[15:12] == 4'hE) pc = {cur_pcout[15:12], cur_instr[11:0]};
          else pc = cur_pcout + 16'd1;
          break;
        end
        if (n > budget + 100) return;
      end
      if (halt) begin
        for (int h = 0; h < 20; h++) begin
          begin_cycle(0, '0, 0, 1);
          Redirect = 1'($urandom_range(1));
          step();
        end
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc_no);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; Imem_Ack = 0; Imem_Data = '0; Stall = 0; Redirect = 0; Redirect_Addr = '0; cyc_no = -1;

    // back-to-back single-cycle acks, one instruction every 3 cycles
    setup(0, -1, '0, -1, -1, -1, 0, 0, 0);
    mem[16'h0] = 16'h1234; mem[16'h1] = 16'h2000; mem[16'h2] = 16'h3000; mem[16'h3] = 16'hF000;
    run_prog(200);
    chk("s1_fet0_cyc", 32'(fet_q[0].c), 32'd1);
    chk("s1_fet0_addr", 32'(fet_q[0].a), 32'h0);
    chk("s1_iss0_cyc", 32'(iss_q[0].c), 32'd2);
    chk("s1_iss0_op", 32'(iss_q[0].w[15:12]), 32'h1);
    chk("s1_iss1", {iss_q[1].c[15:0], iss_q[1].a}, {16'd5, 16'h0001});
    chk("s1_iss2", {iss_q[2].c[15:0], iss_q[2].a}, {16'd8, 16'h0002});
    chk("s1_iss2_op", 32'(iss_q[2].w[15:12]), 32'h3);

    // ack held off for 4 cycles
    setup(4, -1, '0, -1, -1, -1, 0, 0, 0);
    mem[16'h0] = 16'h7000; mem[16'h1] = 16'hF000;
    run_prog(200);
    chk("s2_iss0_cyc", 32'(iss_q[0].c), 32'd6);
    chk("s2_fet1", {fet_q[1].c[15:0], fet_q[1].a}, {16'd8, 16'h0001});

    // redirect to 0x3010, jump word there, then halt with redirects ignored
    setup(0, 2, 16'h3010, -1, -1, -1, 0, 0, 0);
    mem[16'h0] = 16'h1000; mem[16'h3010] = 16'hE0A5; mem[16'h30A5] = 16'hF000;
    run_prog(200);
    chk("s3_nfet", 32'(fet_q.size()), 32'd3);
    chk("s3_fet2", {fet_q[2].c[15:0], fet_q[2].a}, {16'd7, 16'h30A5});

    // stall 5 cycles in issue with a redirect on the 3rd stall cycle
    setup(0, 4, 16'h0040, 2, 6, -1, 0, 0, 0);
    mem[16'h0] = 16'h1111; mem[16'h40] = 16'hF000;
    run_prog(200);
    chk("s4_fet1", {fet_q[1].c[15:0], fet_q[1].a}, {16'd6, 16'h0040});
    chk("s4_iss1", {iss_q[1].c[15:0], iss_q[1].a}, {16'd7, 16'h0040});

    // redirect during wait: the acked word is discarded
    setup(2, 1, 16'h0100, -1, -1, -1, 0, 0, 0);
    mem[16'h0] = 16'h5555; mem[16'h100] = 16'hF000;
    run_prog(200);
    chk("s5_fet1", {fet_q[1].c[15:0], fet_q[1].a}, {16'd5, 16'h0100});
    chk("s5_niss", 32'(iss_q.size()), 32'd1);
    chk("s5_iss0", {iss_q[0].a, iss_q[0].w}, {16'h0100, 16'hF000});

    // PC wrap from 0xFFFF to 0x0000
    setup(0, 2, 16'hFFFF, -1, -1, -1, 0, 0, 0);
    mem[16'h0] = 16'h1000; mem[16'hFFFF] = 16'h2222; mem[16'h1] = 16'hF000;
    run_prog(200);
    chk("s6_fet2", {fet_q[2].c[15:0], fet_q[2].a}, {16'd7, 16'h0000});

    // reset in the middle of a wait, with an ack in the same cycle
    setup(3, -1, '0, -1, -1, 2, 0, 0, 0);
    mem[16'h0] = 16'hF000;
    run_prog(200);
    chk("s7_nfet", 32'(fet_q.size()), 32'd2);
    chk("s7_iss0_cyc", 32'(iss_q[0].c), 32'd5);

    // randomized traffic
    setup(-1, -1, '0, -1, -1, -1, 25, 8, 5);
    for (int r = 0; r < 12; r++) run_prog(300);

    chk_en = 0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
